// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes and a constant-foldable clog2 helper.
// Revision: 1.0
`default_nettype none

package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_chan_hold.sv
// axi_lite_chan_hold: one-entry valid/payload holding register for an AXI4-Lite request channel.
// Revision: 1.0
`default_nettype none

module axi_lite_chan_hold #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [W-1:0] payload_i,
  input  logic         block_i,
  input  logic         clear_i,
  output logic         ready_o,
  output logic         avail_o,
  output logic [W-1:0] payload_o
);

  logic         held_q, held_d;
  logic [W-1:0] payload_q, payload_d;
  logic         w_hs;

  assign ready_o   = !held_q && !block_i;
  assign w_hs      = valid_i && ready_o;
  // Payload is usable in the same cycle it handshakes, so a commit needs no extra cycle.
  assign avail_o   = held_q || w_hs;
  assign payload_o = held_q ? payload_q : payload_i;

  always_comb begin
    held_d    = held_q;
    payload_d = payload_q;
    if (w_hs) payload_d = payload_i;
    if (clear_i)   held_d = 1'b0;
    else if (w_hs) held_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      held_q    <= 1'b0;
      payload_q <= '0;
    end else begin
      held_q    <= held_d;
      payload_q <= payload_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_slave_regfile_n.sv
// axi_slave_regfile_n: AXI4-Lite slave register file with per-register read-only status inputs.
// Revision: 1.0
`default_nettype none

module axi_slave_regfile_n
  import axi_lite_pkg::*;
#(
  parameter int                     C_S_AXI_DATA_WIDTH = 32,
  parameter int                     C_S_AXI_ADDR_WIDTH = 8,
  parameter int                     NUM_REGS           = 16,
  parameter logic [NUM_REGS-1:0]    RO_MASK            = '0
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REG_OUT,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REG_IN,
  output logic [NUM_REGS-1:0]                  WR_PULSE,
  output logic [NUM_REGS-1:0]                  RD_PULSE
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = clog2(DW / 8);
  localparam int IDX_W    = clog2(NUM_REGS);

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0] rd_pulse_q, rd_pulse_d;

  logic                w_aw_avail, w_w_avail, w_commit, w_block, w_ar_hs;
  logic [AW-1:0]       w_aw_addr, w_aw_word, w_ar_word;
  logic [SW+DW-1:0]    w_w_payload;
  logic [IDX_W-1:0]    w_aw_idx, w_ar_idx;
  logic                w_aw_in, w_ar_in;

  // Readies are forced low during reset so nothing is accepted while state is being cleared.
  assign w_block = bvalid_q || S_AXI_ARESET;

  axi_lite_chan_hold #(.W(AW)) u_aw_hold (
    .clk_i(S_AXI_ACLK), .rst_i(S_AXI_ARESET), .valid_i(S_AXI_AWVALID),
    .payload_i(S_AXI_AWADDR), .block_i(w_block), .clear_i(w_commit),
    .ready_o(S_AXI_AWREADY), .avail_o(w_aw_avail), .payload_o(w_aw_addr)
  );

  axi_lite_chan_hold #(.W(SW + DW)) u_w_hold (
    .clk_i(S_AXI_ACLK), .rst_i(S_AXI_ARESET), .valid_i(S_AXI_WVALID),
    .payload_i({S_AXI_WSTRB, S_AXI_WDATA}), .block_i(w_block), .clear_i(w_commit),
    .ready_o(S_AXI_WREADY), .avail_o(w_w_avail), .payload_o(w_w_payload)
  );

  assign w_commit  = w_aw_avail && w_w_avail;
  assign w_aw_word = w_aw_addr >> ADDR_LSB;
  assign w_ar_word = S_AXI_ARADDR >> ADDR_LSB;
  assign w_aw_idx  = w_aw_word[IDX_W-1:0];
  assign w_ar_idx  = w_ar_word[IDX_W-1:0];
  assign w_aw_in   = w_aw_word < AW'(NUM_REGS);
  assign w_ar_in   = w_ar_word < AW'(NUM_REGS);
  assign S_AXI_ARREADY = !rvalid_q && !S_AXI_ARESET;
  assign w_ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    regs_d     = regs_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_pulse_d = '0;

    if (w_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_aw_in && w_aw_idx == IDX_W'(i) && !RO_MASK[i]) begin
          bresp_d       = RESP_OKAY;
          wr_pulse_d[i] = 1'b1;
          for (int b = 0; b < SW; b++) begin
            if (w_w_payload[DW+b]) regs_d[i][b*8 +: 8] = w_w_payload[b*8 +: 8];
          end
        end
      end
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Reads sample regs_q, so a same-edge write is never visible to the concurrent read.
    if (w_ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_SLVERR;
      rdata_d  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_ar_in && w_ar_idx == IDX_W'(i)) begin
          rresp_d       = RESP_OKAY;
          rd_pulse_d[i] = 1'b1;
          rdata_d       = RO_MASK[i] ? REG_IN[i*DW +: DW] : regs_q[i];
        end
      end
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
      assign REG_OUT[i*DW +: DW] = regs_q[i];
    end
  endgenerate

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign WR_PULSE     = wr_pulse_q;
  assign RD_PULSE     = rd_pulse_q;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, REG_IN};

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_regfile_n.sv
// tb_axi_slave_regfile_n: directed self-checking bench for axi_slave_regfile_n (reg3 read-only).
// Revision: 1.0
`default_nettype none

module tb_axi_slave_regfile_n;

  localparam int DW = 32;
  localparam int NR = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      awaddr = '0, araddr = '0;
  logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]     wdata = '0;
  logic [3:0]      wstrb = '0;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [1:0]      bresp, rresp;
  logic [31:0]     rdata;
  logic [NR*DW-1:0] reg_out, reg_in;
  logic [NR-1:0]   wr_pulse, rd_pulse;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_slave_regfile_n #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .NUM_REGS(16), .RO_MASK(16'h0008)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG_OUT(reg_out), .REG_IN(reg_in), .WR_PULSE(wr_pulse), .RD_PULSE(rd_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return reg_out[i*DW +: DW];
  endfunction

  // Simultaneous AW+W, then complete B; reports response and pulse seen after the commit edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp, output logic [NR-1:0] pulse);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    resp = bvalid ? bresp : 2'bxx;
    pulse = wr_pulse;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                    output logic [NR-1:0] pulse);
    araddr = a; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    d = rvalid ? rdata : 32'hxxxxxxxx;
    resp = rvalid ? rresp : 2'bxx;
    pulse = rd_pulse;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || reg_out !== '0 || wr_pulse !== '0) begin
      n_err++;
      $display("FAIL reset_state: rdy/vld=%b reg_out_nz=%0d wr_pulse=%h required all 0",
               {awready, wready, arready, bvalid, rvalid}, reg_out != '0, wr_pulse);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_simul_write();
    awaddr = 8'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_err++;
      $display("FAIL simul_bresp: bvalid=%b bresp=%b required 1/00", bvalid, bresp);
    end
    n_cmp++;
    if (reg_at(1) !== 32'hDEADBEEF || wr_pulse !== 16'h0002) begin
      n_err++;
      $display("FAIL simul_reg1: reg1=%h pulse=%h required DEADBEEF/0002", reg_at(1), wr_pulse);
    end
    tick();
    n_cmp++;
    if (wr_pulse !== 16'h0000 || bvalid !== 1'b1) begin
      n_err++;
      $display("FAIL simul_pulse_width: pulse=%h bvalid=%b required 0000/1", wr_pulse, bvalid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL simul_bclear: bvalid=%b required 0", bvalid);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [NR-1:0] p;
    wr(8'h08, 32'hAAAAAAAA, 4'hF, r, p);
    wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
        n_err++;
        $display("FAIL w_held_c%0d: wready=%b awready=%b bvalid=%b required 0/1/0", c, wready, awready, bvalid);
      end
      if (c < 2) tick();
    end
    awaddr = 8'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_at(2) !== 32'hAAAA5678 || wready !== 1'b0) begin
      n_err++;
      $display("FAIL w_first_commit: bvalid=%b bresp=%b reg2=%h wready=%b required 1/00/AAAA5678/0",
               bvalid, bresp, reg_at(2), wready);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0 || wready !== 1'b1) begin
      n_err++;
      $display("FAIL w_first_done: bvalid=%b wready=%b required 0/1", bvalid, wready);
    end
  endtask

  task automatic test_read_only();
    logic [1:0] r; logic [NR-1:0] p; logic [31:0] d;
    wr(8'h0C, 32'h11111111, 4'hF, r, p);
    n_cmp++;
    if (r !== 2'b10 || p !== 16'h0000 || reg_at(3) !== 32'h0) begin
      n_err++;
      $display("FAIL ro_write: bresp=%b pulse=%h reg3=%h required 10/0000/00000000", r, p, reg_at(3));
    end
    rd(8'h0C, d, r, p);
    n_cmp++;
    if (d !== 32'hCAFEF00D || r !== 2'b00 || p !== 16'h0008) begin
      n_err++;
      $display("FAIL ro_read: rdata=%h rresp=%b pulse=%h required CAFEF00D/00/0008", d, r, p);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [NR-1:0] p; logic [31:0] d;
    logic [NR*DW-1:0] snap;
    rd(8'h40, d, r, p);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b10 || p !== 16'h0000) begin
      n_err++;
      $display("FAIL oor_read: rdata=%h rresp=%b pulse=%h required 0/10/0000", d, r, p);
    end
    snap = reg_out;
    wr(8'h40, 32'hFFFFFFFF, 4'hF, r, p);
    n_cmp++;
    if (r !== 2'b10 || p !== 16'h0000 || reg_out !== snap) begin
      n_err++;
      $display("FAIL oor_write: bresp=%b pulse=%h changed=%0d required 10/0000/0", r, p, reg_out != snap);
    end
    rd(8'h04, d, r, p);
    n_cmp++;
    if (d !== 32'hDEADBEEF || r !== 2'b00 || p !== 16'h0002) begin
      n_err++;
      $display("FAIL rw_read: rdata=%h rresp=%b pulse=%h required DEADBEEF/00/0002", d, r, p);
    end
  endtask

  task automatic test_b_backpressure();
    awaddr = 8'h10; wdata = 32'h00000055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h04; arvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_c%0d: bvalid=%b bresp=%b awready=%b wready=%b required 1/00/0/0",
                 c, bvalid, bresp, awready, wready);
      end
      if (c == 0) begin
        arvalid = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin
          n_err++;
          $display("FAIL bp_read: rvalid=%b rdata=%h rresp=%b required 1/DEADBEEF/00", rvalid, rdata, rresp);
        end
        rready = 1'b1;
      end else begin
        rready = 1'b0;
      end
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || reg_at(4) !== 32'h55) begin
      n_err++;
      $display("FAIL bp_done: bvalid=%b rvalid=%b reg4=%h required 0/0/00000055", bvalid, rvalid, reg_at(4));
    end
  endtask

  task automatic test_same_edge();
    awaddr = 8'h04; wdata = 32'h01010101; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h04; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n_cmp++;
    if (rdata !== 32'hDEADBEEF || reg_at(1) !== 32'h01010101) begin
      n_err++;
      $display("FAIL same_edge: rdata=%h reg1=%h required DEADBEEF/01010101", rdata, reg_at(1));
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    awaddr = 8'h14; awvalid = 1'b1; araddr = 8'h04; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b0 || rresp !== 2'b0 ||
        rdata !== 32'h0 || reg_out !== '0 || wr_pulse !== '0 || rd_pulse !== '0) begin
      n_err++;
      $display("FAIL mid_reset: rdy/vld=%b bresp=%b rresp=%b rdata=%h reg_out_nz=%0d required all 0",
               {awready, wready, arready, bvalid, rvalid}, bresp, rresp, rdata, reg_out != '0);
    end
    rst = 1'b0;
    #1;
    wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0 || reg_at(5) !== 32'h0 || awready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_discard: bvalid=%b reg5=%h awready=%b required 0/0/1", bvalid, reg_at(5), awready);
    end
    awaddr = 8'h14; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b1 || reg_at(5) !== 32'h77777777) begin
      n_err++;
      $display("FAIL post_reset_write: bvalid=%b reg5=%h required 1/77777777", bvalid, reg_at(5));
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  initial begin
    reg_in = '0;
    reg_in[3*DW +: DW] = 32'hCAFEF00D;
    test_reset();
    test_simul_write();
    test_w_before_aw();
    test_read_only();
    test_out_of_range();
    test_b_backpressure();
    test_same_edge();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_slave_regfile_n.md
AXI_SLAVE_REGFILE_N -- requirements
Module: axi_slave_regfile_n

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, giving the data width; legal values are 32 or 64.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, giving the byte address width.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, giving the register count; legal range is 2..64.
REQ-004 The block SHALL have parameter RO_MASK, width NUM_REGS, default 0; bit i=1 makes register i read-only and sourced from REG_IN.
REQ-005 The block SHALL have these ports, in this order:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY, S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY: AXI4-Lite slave, standard directions and widths; PROT is ignored.
- REG_OUT  out  NUM_REGS*DW  flat image of the RW registers; register i occupies bits [i*DW +: DW].
- REG_IN  in  NUM_REGS*DW  status inputs, used only for RO_MASK bits.
- WR_PULSE  out  NUM_REGS  one-cycle strobe per successful write.
- RD_PULSE  out  NUM_REGS  one-cycle strobe per successful read.

Function
REQ-006 Register index SHALL be addr[ADDR_LSB +: IDX_W], with ADDR_LSB=clog2(DW/8) and IDX_W=clog2(NUM_REGS); the upper address bits SHALL also decode, so any index >= NUM_REGS is out of range.
REQ-007 AW and W SHALL be accepted independently, each into its own one-entry holding register:
- AWREADY = !aw_held && !BVALID.
- WREADY = !w_held && !BVALID.
REQ-008 Write commit SHALL occur at the clock edge where the address and data are both available (held or handshaking that cycle); at that edge the holds clear and BVALID rises, giving 1-cycle latency from the last handshake.
REQ-009 At commit, the register SHALL be updated per byte where WSTRB[b]=1; bytes with WSTRB[b]=0 SHALL be unchanged; WSTRB=0 SHALL return OKAY with no change.
REQ-010 A write to an out-of-range or RO index SHALL NOT modify state, SHALL return BRESP=2'b10 (SLVERR), and SHALL NOT assert WR_PULSE.
REQ-011 An OKAY commit SHALL assert WR_PULSE[idx] for exactly the cycle after the commit edge.
REQ-012 BVALID SHALL hold with BRESP stable until BREADY; AWREADY/WREADY SHALL be low while BVALID is high (one outstanding write).
REQ-013 ARREADY SHALL equal !RVALID; at the AR handshake edge, RDATA/RRESP SHALL be captured and RVALID SHALL rise (1-cycle latency).
REQ-014 Read data SHALL be:
- RW index: the register value.
- RO index: REG_IN sampled at the handshake edge.
- Out of range: 0 with RRESP=SLVERR.
REQ-015 RD_PULSE[idx] SHALL assert for one cycle after an in-range AR handshake.
REQ-016 RDATA/RRESP SHALL hold until RREADY while RVALID is high.
REQ-017 When a read and a write commit target the same register on the same edge, the read SHALL return the pre-write value.
REQ-018 The read and write paths SHALL be fully independent; a read SHALL NOT stall for a pending B response or vice versa.

Reset
REQ-019 While S_AXI_ARESET=1, the following SHALL be 0 on the next edge: all READY/VALID outputs, BRESP, RRESP, RDATA, REG_OUT, WR_PULSE, RD_PULSE, and both hold flags.
REQ-020 Reset asserted mid-transaction SHALL discard held AW/W and pending B/R responses without committing any write.
REQ-021 The first cycle after reset release SHALL accept AW, W and AR.

Structure
REQ-022 Package axi_lite_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the clog2 helper used for ADDR_LSB/IDX_W.
REQ-023 Sub-module axi_lite_chan_hold (one-entry valid/payload holding register with ready=!held, clear on commit) SHALL be instantiated twice, for AW and W.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Simultaneous AW(0x04)+W(0xDEADBEEF, strb 0xF) -> BVALID on next cycle with OKAY; REG_OUT reg1 = 0xDEADBEEF; WR_PULSE[1] for one cycle.
- W 3 cycles before AW(0x08), strb 0x3, data 0x12345678 on reg2 previously 0xAAAAAAAA -> reg2 = 0xAAAA5678; WREADY low after W accepted until B completes.
- With RO_MASK bit3 set and REG_IN reg3 = 0xCAFEF00D: write 0x0C -> SLVERR, no WR_PULSE; read 0x0C -> 0xCAFEF00D OKAY; RD_PULSE[3].
- Read addr 0x40 (index 16 with NUM_REGS=16) -> RDATA 0, RRESP SLVERR; write there -> SLVERR, REG_OUT unchanged.
- BREADY held low 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0; concurrent read of reg1 completes normally.
- Reset asserted with AW held and RVALID pending -> all outputs 0 next cycle; held write never commits.
